wb_serial_tx_sched: RTL and testbench

//  Wishbone master that drains a byte stream into the NS16550-style serial peripheral.

---
 rtl/wb_serial_tx_sched.sv | 179 +++++++++++++++++
 tb/tb_wb_serial_tx_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_serial_tx_sched.sv
// Wishbone master that drains a byte FIFO into an NS16550-style serial block:
// poll ISR until THR is empty, then write one byte to THR, with an ack timeout on every cycle.
module wb_serial_tx_sched #(
    parameter int              AW          = 32,
    parameter int              DW          = 32,
    parameter logic [AW-1:0]   BASE_ADDR   = '0,
    parameter int              DEPTH       = 16,
    parameter int              POLL_GAP    = 4,
    parameter int              ACK_TIMEOUT = 64,
    parameter int              THRE_BIT    = 1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_resetn_i,
    input  logic [7:0]               s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [AW-1:0]            wb_adr_o,
    output logic [DW-1:0]            wb_dat_o,
    input  logic [DW-1:0]            wb_dat_i,
    output logic                     wb_we_o,
    output logic [DW/8-1:0]          wb_sel_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    input  logic                     wb_ack_i,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy,
    output logic                     timeout_err
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CMAX = (ACK_TIMEOUT > POLL_GAP) ? ACK_TIMEOUT : POLL_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [AW-1:0] ADR_THR = BASE_ADDR;
    localparam logic [AW-1:0] ADR_ISR = BASE_ADDR + AW'(2);

    typedef enum logic [2:0] {S_IDLE, S_POLL, S_BACKOFF, S_WRITE, S_GAP1} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            wr_next_q;
    logic            cyc_q, we_q, to_q;
    logic [AW-1:0]   adr_q;
    logic [DW-1:0]   dat_q;

    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     level_q, level_d;
    logic            full_q;
    logic            push, pop;

    // Only the THRE bit of ISR matters; the rest is folded here to mark it intentionally unused.
    logic unused_dat;
    assign unused_dat = ^wb_dat_i;

    assign s_ready = !full_q && wb_resetn_i;
    assign push    = s_valid && s_ready;
    assign pop     = (state_q == S_WRITE) && cyc_q && wb_ack_i;

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + 1'b1;
        else if (!push && pop)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (push)
            mem[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge wb_clk_i or negedge wb_resetn_i) begin
        if (!wb_resetn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == (PW+1)'(DEPTH));
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_resetn_i) begin
        if (!wb_resetn_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_next_q <= 1'b0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            to_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
        end else begin
            to_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (level_q != '0) begin
                        state_q <= S_POLL;
                        cyc_q   <= 1'b1;
                        we_q    <= 1'b0;
                        adr_q   <= ADR_ISR;
                        dat_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_POLL, S_WRITE: begin
                    // An ack in the timeout cycle still completes the transfer.
                    if (wb_ack_i) begin
                        cyc_q <= 1'b0;
                        we_q  <= 1'b0;
                        cnt_q <= '0;
                        if (state_q == S_WRITE) begin
                            state_q   <= S_GAP1;
                            wr_next_q <= 1'b0;
                        end else if (wb_dat_i[THRE_BIT]) begin
                            state_q   <= S_GAP1;
                            wr_next_q <= 1'b1;
                        end else begin
                            state_q <= S_BACKOFF;
                        end
                    end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        to_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_BACKOFF;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_BACKOFF: begin
                    if (cnt_q == CW'(POLL_GAP - 1)) begin
                        state_q <= S_POLL;
                        cyc_q   <= 1'b1;
                        we_q    <= 1'b0;
                        adr_q   <= ADR_ISR;
                        dat_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GAP1: begin
                    if (wr_next_q) begin
                        state_q <= S_WRITE;
                        cyc_q   <= 1'b1;
                        we_q    <= 1'b1;
                        adr_q   <= ADR_THR;
                        dat_q   <= DW'(mem[rd_ptr_q]);
                        cnt_q   <= '0;
                    end else if (level_q != '0) begin
                        // Skip IDLE when more bytes wait: keeps one byte per 6 cycles.
                        state_q <= S_POLL;
                        cyc_q   <= 1'b1;
                        we_q    <= 1'b0;
                        adr_q   <= ADR_ISR;
                        dat_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = {{(DW/8-1){1'b0}}, cyc_q};
    assign fifo_level  = level_q;
    assign busy        = (state_q != S_IDLE) || (level_q != '0);
    assign timeout_err = to_q;
endmodule

// File: tb/tb_wb_serial_tx_sched.sv
// Bench for wb_serial_tx_sched: Wishbone slave model with a THR-write scoreboard,
// a vector table of byte/ISR patterns, and hand sequences for stall, timeout, reset and push-on-ack.
module tb_wb_serial_tx_sched;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i = '1;
    logic          wb_we_o;
    logic [3:0]    wb_sel_o;
    logic          wb_cyc_o, wb_stb_o;
    logic          wb_ack_i = 1'b0;
    logic [4:0]    fifo_level;
    logic          busy, timeout_err;

    always #5 clk = ~clk;

    wb_serial_tx_sched #(.AW(AW), .DW(DW), .BASE_ADDR(BASE), .DEPTH(16), .POLL_GAP(4),
                         .ACK_TIMEOUT(64), .THRE_BIT(1)) dut (
        .wb_clk_i(clk), .wb_resetn_i(rstn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
        .fifo_level(fifo_level), .busy(busy), .timeout_err(timeout_err));

    int tests = 0, fails = 0;
    logic [7:0] exp_mem [256];
    int exp_wr = 0, flush_to = 0, isr_zero_until = 0;
    logic rd_on = 1'b1, wr_on = 1'b1;

    // slave-side state (written only by the slave/monitor processes)
    int exp_rd = 0, sb_err = 0, n_polls = 0, n_writes = 0, n_to = 0, proto_err = 0, scnt = 0;

    // Slave: ack one cycle after strobe when enabled; THR writes popped from the scoreboard.
    always @(negedge clk) begin
        if (exp_rd < flush_to) exp_rd = flush_to;
        if (rstn && wb_cyc_o && wb_stb_o) begin
            scnt++;
            if (scnt > 1 && (wb_we_o ? wr_on : rd_on)) begin
                wb_ack_i = 1'b1;
                if (wb_we_o) begin
                    n_writes++;
                    if (exp_rd >= exp_wr) begin
                        sb_err++;
                        $display("FAIL thr_unexpected: got dat %08h, no byte expected", wb_dat_o);
                    end else begin
                        if (wb_dat_o !== {24'h0, exp_mem[exp_rd]} || wb_adr_o !== BASE) begin
                            sb_err++;
                            $display("FAIL thr_write: got adr %08h dat %08h, expected adr %08h dat %08h",
                                     wb_adr_o, wb_dat_o, BASE, {24'h0, exp_mem[exp_rd]});
                        end
                        exp_rd++;
                    end
                end else begin
                    n_polls++;
                    if (wb_adr_o !== BASE + 32'h2) begin
                        sb_err++;
                        $display("FAIL isr_addr: got %08h expected %08h", wb_adr_o, BASE + 32'h2);
                    end
                    wb_dat_i = (n_polls <= isr_zero_until) ? 32'hFFFF_FFFD : 32'h0000_0002;
                end
            end else begin
                wb_ack_i = 1'b0;
                wb_dat_i = '1;
            end
        end else begin
            scnt = 0;
            wb_ack_i = 1'b0;
            wb_dat_i = '1;
        end
    end

    always @(negedge clk) begin
        if (timeout_err) n_to++;
        if (wb_stb_o !== wb_cyc_o || wb_sel_o !== (wb_cyc_o ? 4'b0001 : 4'b0000)) proto_err++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        int budget = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (!s_ready) begin
            chk("push_accept", {31'b0, s_ready}, 32'd1);
            s_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_mem[exp_wr] = b;
            exp_wr++;
            #1 s_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while ((busy || exp_rd != exp_wr) && budget < 3000);
        chk({name, "_drained"}, exp_wr - exp_rd, 32'd0);
        chk({name, "_busy_end"}, {31'b0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] base;
        int nbytes, zeros, exp_polls, exp_writes, exp_busy;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int p0, w0, t0, bc, len, act;
        logic       c_cyc[8], c_we[8], c_busy[8];
        logic [31:0] c_adr[8], c_dat[8];
        logic [3:0] c_sel[8];
        logic [4:0] c_lvl[8];

        vecs[0] = '{base: 8'h41, nbytes: 1, zeros: 0, exp_polls: 1, exp_writes: 1, exp_busy: 7};
        vecs[1] = '{base: 8'h50, nbytes: 3, zeros: 0, exp_polls: 3, exp_writes: 3, exp_busy: 17};
        vecs[2] = '{base: 8'h60, nbytes: 1, zeros: 2, exp_polls: 3, exp_writes: 1, exp_busy: 19};
        vecs[3] = '{base: 8'h70, nbytes: 2, zeros: 1, exp_polls: 3, exp_writes: 2, exp_busy: 18};

        // reset state
        #2;
        chk("rst_cyc", {31'b0, wb_cyc_o}, 0);
        chk("rst_stb", {31'b0, wb_stb_o}, 0);
        chk("rst_we", {31'b0, wb_we_o}, 0);
        chk("rst_sel", {28'b0, wb_sel_o}, 0);
        chk("rst_level", {27'b0, fifo_level}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_ready", {31'b0, s_ready}, 0);
        chk("rst_to", {31'b0, timeout_err}, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, s_ready}, 1);

        // single byte: cycle-exact latency
        push_byte(8'h41);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            c_cyc[c] = wb_cyc_o; c_we[c] = wb_we_o; c_adr[c] = wb_adr_o; c_dat[c] = wb_dat_o;
            c_sel[c] = wb_sel_o; c_lvl[c] = fifo_level; c_busy[c] = busy;
        end
        chk("t1_c0_level", {27'b0, c_lvl[0]}, 1);
        chk("t1_c0_cyc", {31'b0, c_cyc[0]}, 0);
        chk("t1_c1_poll", {30'b0, c_cyc[1], c_we[1]}, 32'b10);
        chk("t1_c1_adr", c_adr[1], BASE + 32'h2);
        chk("t1_c3_gap", {31'b0, c_cyc[3]}, 0);
        chk("t1_c4_write", {30'b0, c_cyc[4], c_we[4]}, 32'b11);
        chk("t1_c4_adr", c_adr[4], BASE);
        chk("t1_c4_dat", c_dat[4], 32'h0000_0041);
        chk("t1_c4_sel", {28'b0, c_sel[4]}, 32'h1);
        chk("t1_c5_level", {27'b0, c_lvl[5]}, 1);
        chk("t1_c6_level", {27'b0, c_lvl[6]}, 0);
        chk("t1_c7_busy", {31'b0, c_busy[7]}, 0);
        wait_idle("t1");

        // vector table: byte counts and ISR-busy poll patterns
        for (int i = 0; i < 4; i++) begin
            p0 = n_polls; w0 = n_writes; t0 = n_to;
            isr_zero_until = p0 + vecs[i].zeros;
            for (int k = 0; k < vecs[i].nbytes; k++) push_byte(vecs[i].base + 8'(k));
            bc = 0;
            do begin
                @(negedge clk);
                if (busy) bc++;
            end while (busy && bc < 500);
            chk($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].exp_busy);
            chk($sformatf("vec%0d_polls", i), n_polls - p0, vecs[i].exp_polls);
            chk($sformatf("vec%0d_writes", i), n_writes - w0, vecs[i].exp_writes);
            chk($sformatf("vec%0d_timeouts", i), n_to - t0, 0);
            wait_idle($sformatf("vec%0d", i));
        end

        // fill FIFO with slave stalled; 17th byte held until space frees
        rd_on = 1'b0; wr_on = 1'b0; t0 = n_to;
        for (int k = 0; k < 16; k++) push_byte(8'(k));
        @(negedge clk);
        chk("t3_level_full", {27'b0, fifo_level}, 16);
        chk("t3_ready_full", {31'b0, s_ready}, 0);
        s_valid = 1'b1; s_data = 8'h10;
        repeat (3) @(negedge clk);
        chk("t3_ready_held", {31'b0, s_ready}, 0);
        chk("t3_level_held", {27'b0, fifo_level}, 16);
        rd_on = 1'b1; wr_on = 1'b1;
        push_byte(8'h10);
        wait_idle("t3");
        chk("t3_timeouts", n_to - t0, 0);

        // THR write never acked: timeout, then same byte rewritten
        wr_on = 1'b0; t0 = n_to; w0 = n_writes; bc = 0;
        push_byte(8'h5A);
        do begin
            @(negedge clk);
            bc++;
        end while (!(wb_cyc_o && wb_we_o) && bc < 100);
        len = 0;
        while (wb_cyc_o && len < 200) begin
            len++;
            @(negedge clk);
        end
        chk("t4_stb_len", len, 64);
        chk("t4_to_pulse", {31'b0, timeout_err}, 1);
        chk("t4_level", {27'b0, fifo_level}, 1);
        wr_on = 1'b1;
        wait_idle("t4");
        chk("t4_timeouts", n_to - t0, 1);
        chk("t4_writes", n_writes - w0, 1);

        // reset mid-WRITE with 5 bytes queued
        wr_on = 1'b0; bc = 0;
        for (int k = 0; k < 5; k++) push_byte(8'hA0 + 8'(k));
        do begin
            @(negedge clk);
            bc++;
        end while (!(wb_cyc_o && wb_we_o) && bc < 100);
        #1 rstn = 1'b0;
        #1;
        chk("t5_cyc_stb_we", {29'b0, wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        chk("t5_level", {27'b0, fifo_level}, 0);
        chk("t5_busy", {31'b0, busy}, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        flush_to = exp_wr;
        wr_on = 1'b1; p0 = n_polls; act = 0;
        repeat (20) begin
            @(negedge clk);
            if (wb_cyc_o) act++;
        end
        chk("t5_no_activity", act, 0);
        chk("t5_no_polls", n_polls - p0, 0);
        push_byte(8'hB5);
        wait_idle("t5");

        // push in the same cycle as a THR-write ack at level 3
        w0 = n_writes; bc = 0;
        for (int k = 0; k < 3; k++) push_byte(8'hC0 + 8'(k));
        do begin
            @(negedge clk);
            #1 bc++;
        end while (!(wb_ack_i && wb_we_o && fifo_level == 5'd3) && bc < 50);
        s_valid = 1'b1; s_data = 8'hC3;
        chk("t6_ready", {31'b0, s_ready}, 1);
        @(posedge clk);
        exp_mem[exp_wr] = 8'hC3;
        exp_wr++;
        #1 s_valid = 1'b0;
        @(negedge clk);
        chk("t6_level", {27'b0, fifo_level}, 3);
        wait_idle("t6");
        chk("t6_writes", n_writes - w0, 4);

        chk("scoreboard_errors", sb_err, 0);
        chk("protocol_errors", proto_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
